// File: rtl/mig_req_arb.sv
// Round-robin arbiter for two masters in front of the MIG req/wdq/rdq queues.
// Optional MIG_ARB_ERR_EN: drop orphan rdq data and flag sticky arb_err.
module mig_req_arb #(
  parameter int TAG_DEPTH = 8,
  parameter int TAG_AW    = 3
) (
  input  logic         mclk,
  input  logic         mrst_n,
  input  logic         m0_req,
  output logic         m0_ack,
  input  logic [31:0]  m0_addr,
  input  logic         m0_rd_bwt,
  input  logic [127:0] m0_wdata,
  output logic         m0_rvalid,
  output logic [127:0] m0_rdata,
  input  logic         m1_req,
  output logic         m1_ack,
  input  logic [31:0]  m1_addr,
  input  logic         m1_rd_bwt,
  input  logic [127:0] m1_wdata,
  output logic         m1_rvalid,
  output logic [127:0] m1_rdata,
  output logic         req_wen,
  output logic [31:0]  req_qwaddr,
  output logic         req_wd_bwt,
  input  logic         req_wqfull,
  output logic         wdq_wen,
  output logic [127:0] wdq_wdata,
  input  logic         wdq_wqfull,
  output logic         rdq_rnext,
  input  logic         rdq_rqempty,
  input  logic [127:0] rdq_rdata,
  output logic         arb_err
);

  localparam logic [TAG_AW:0] FULL_CNT = (TAG_AW+1)'(TAG_DEPTH);

  logic                 rr_last_q, rr_last_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic [TAG_AW-1:0]    wptr_q, wptr_d;
  logic [TAG_AW-1:0]    rptr_q, rptr_d;
  logic [TAG_AW:0]      cnt_q, cnt_d;
  logic                 m0_rvalid_q, m0_rvalid_d;
  logic                 m1_rvalid_q, m1_rvalid_d;
  logic [127:0]         m0_rdata_q, m0_rdata_d;
  logic [127:0]         m1_rdata_q, m1_rdata_d;

  logic tag_full, e0, e1, g0, g1;
  logic push, pop, head;

  // eligibility and round-robin grant
  always_comb begin
    tag_full = (cnt_q == FULL_CNT);
    e0 = m0_req & ~req_wqfull &
         (m0_rd_bwt ? ~tag_full : ~wdq_wqfull);
    e1 = m1_req & ~req_wqfull &
         (m1_rd_bwt ? ~tag_full : ~wdq_wqfull);
    g0 = e0 & (~e1 | rr_last_q);
    g1 = e1 & (~e0 | ~rr_last_q);
  end

  // queue pushes for the granted master; all zero when idle
  always_comb begin
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    req_wen    = 1'b0;
    req_qwaddr = '0;
    req_wd_bwt = 1'b0;
    wdq_wen    = 1'b0;
    wdq_wdata  = '0;
    push       = 1'b0;
    unique case (1'b1)
      g0: begin
        m0_ack     = 1'b1;
        req_wen    = 1'b1;
        req_qwaddr = m0_addr;
        req_wd_bwt = m0_rd_bwt;
        wdq_wen    = ~m0_rd_bwt;
        wdq_wdata  = m0_rd_bwt ? '0 : m0_wdata;
        push       = m0_rd_bwt;
      end
      g1: begin
        m1_ack     = 1'b1;
        req_wen    = 1'b1;
        req_qwaddr = m1_addr;
        req_wd_bwt = m1_rd_bwt;
        wdq_wen    = ~m1_rd_bwt;
        wdq_wdata  = m1_rd_bwt ? '0 : m1_wdata;
        push       = m1_rd_bwt;
      end
      default: ;
    endcase
  end

  // tag fifo, read steering and next-state
  always_comb begin
    pop         = ~rdq_rqempty & (cnt_q != '0);
    head        = tag_q[rptr_q];
    rr_last_d   = rr_last_q;
    if (g0) rr_last_d = 1'b0;
    if (g1) rr_last_d = 1'b1;
    tag_d       = tag_q;
    if (push) tag_d[wptr_q] = g1;
    wptr_d      = wptr_q + TAG_AW'(push);
    rptr_d      = rptr_q + TAG_AW'(pop);
    cnt_d       = cnt_q + (TAG_AW+1)'(push)
                - (TAG_AW+1)'(pop);
    m0_rvalid_d = pop & ~head;
    m1_rvalid_d = pop & head;
    m0_rdata_d  = m0_rvalid_d ? rdq_rdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? rdq_rdata : m1_rdata_q;
  end

  // state registers
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      rr_last_q   <= 1'b1;
      tag_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      rr_last_q   <= rr_last_d;
      tag_q       <= tag_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

`ifdef MIG_ARB_ERR_EN
  logic orphan;
  logic err_q, err_d;

  // orphan data is dropped; protocol errors are sticky
  always_comb begin
    orphan    = ~rdq_rqempty & (cnt_q == '0);
    rdq_rnext = pop | orphan;
    err_d     = err_q | orphan | (push & tag_full);
  end

  // sticky error flag
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign arb_err = err_q;
`else
  assign rdq_rnext = pop;
  assign arb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mig_req_arb.sv
// Randomized bench for mig_req_arb with queue-based reference model
// and a decoupled read-return scoreboard.
module tb_mig_req_arb;

  logic         mclk = 1'b0;
  logic         mrst_n = 1'b0;
  logic         m0_req, m0_ack, m0_rd_bwt, m0_rvalid;
  logic [31:0]  m0_addr;
  logic [127:0] m0_wdata, m0_rdata;
  logic         m1_req, m1_ack, m1_rd_bwt, m1_rvalid;
  logic [31:0]  m1_addr;
  logic [127:0] m1_wdata, m1_rdata;
  logic         req_wen, req_wd_bwt, req_wqfull;
  logic [31:0]  req_qwaddr;
  logic         wdq_wen, wdq_wqfull;
  logic [127:0] wdq_wdata;
  logic         rdq_rnext, rdq_rqempty;
  logic [127:0] rdq_rdata;
  logic         arb_err;

  mig_req_arb dut (
    .mclk(mclk), .mrst_n(mrst_n),
    .m0_req(m0_req), .m0_ack(m0_ack), .m0_addr(m0_addr),
    .m0_rd_bwt(m0_rd_bwt), .m0_wdata(m0_wdata),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_ack(m1_ack), .m1_addr(m1_addr),
    .m1_rd_bwt(m1_rd_bwt), .m1_wdata(m1_wdata),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .req_wen(req_wen), .req_qwaddr(req_qwaddr),
    .req_wd_bwt(req_wd_bwt), .req_wqfull(req_wqfull),
    .wdq_wen(wdq_wen), .wdq_wdata(wdq_wdata),
    .wdq_wqfull(wdq_wqfull),
    .rdq_rnext(rdq_rnext), .rdq_rqempty(rdq_rqempty),
    .rdq_rdata(rdq_rdata), .arb_err(arb_err)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    bit           who;
    logic [127:0] d;
  } ret_t;

  int n_cmp = 0;
  int n_bad = 0;

  bit           tagq[$];
  logic [127:0] rdq[$];
  ret_t         expq[$];
  bit           last;
  bit           err_m;
  logic [127:0] last_d0, last_d1;

  int p_req0, p_req1, p_rd0, p_rd1;
  int p_rqf, p_wqf, p_push;
  bit allow_orphan;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic gen(input int pr, input int prd,
                     output logic rq, output logic rd,
                     output logic [31:0] a,
                     output logic [127:0] d);
    rq = ($urandom_range(99) < pr);
    rd = ($urandom_range(99) < prd);
    a  = $urandom;
    d  = rnd128();
  endtask

  task automatic drive_rdq();
    rdq_rqempty = (rdq.size() == 0);
    rdq_rdata   = (rdq.size() == 0) ? '0 : rdq[0];
  endtask

  // one clock: check at negedge, advance model, drive after posedge
  task automatic step();
    int cnt;
    bit e0, e1, g0, g1, pop, orph, exp_rn;
    logic [31:0] ea;
    logic [127:0] ew;
    @(negedge mclk);
    cnt = tagq.size();
    e0 = m0_req && !req_wqfull &&
         (m0_rd_bwt ? (cnt < 8) : !wdq_wqfull);
    e1 = m1_req && !req_wqfull &&
         (m1_rd_bwt ? (cnt < 8) : !wdq_wqfull);
    g0 = e0 && (!e1 || last);
    g1 = e1 && (!e0 || !last);
    ea = g0 ? m0_addr : (g1 ? m1_addr : 32'h0);
    ew = (g0 && !m0_rd_bwt) ? m0_wdata :
         (g1 && !m1_rd_bwt) ? m1_wdata : 128'h0;
    chk("m0_ack", 128'(m0_ack), 128'(g0));
    chk("m1_ack", 128'(m1_ack), 128'(g1));
    chk("req_wen", 128'(req_wen), 128'(g0 || g1));
    chk("req_qwaddr", 128'(req_qwaddr), 128'(ea));
    chk("req_wd_bwt", 128'(req_wd_bwt),
        128'((g0 && m0_rd_bwt) || (g1 && m1_rd_bwt)));
    chk("wdq_wen", 128'(wdq_wen),
        128'((g0 && !m0_rd_bwt) || (g1 && !m1_rd_bwt)));
    chk("wdq_wdata", wdq_wdata, ew);
    pop  = (rdq.size() > 0) && (cnt > 0);
    orph = (rdq.size() > 0) && (cnt == 0);
`ifdef MIG_ARB_ERR_EN
    exp_rn = pop || orph;
`else
    exp_rn = pop;
`endif
    chk("rdq_rnext", 128'(rdq_rnext), 128'(exp_rn));
    chk("arb_err", 128'(arb_err), 128'(err_m));
    if (pop) begin
      ret_t r;
      r.who = tagq.pop_front();
      r.d   = rdq.pop_front();
      expq.push_back(r);
    end
`ifdef MIG_ARB_ERR_EN
    else if (orph) begin
      void'(rdq.pop_front());
      err_m = 1'b1;
    end
`endif
    if (g0 && m0_rd_bwt) tagq.push_back(1'b0);
    if (g1 && m1_rd_bwt) tagq.push_back(1'b1);
    if (g0) last = 1'b0;
    if (g1) last = 1'b1;
    @(posedge mclk);
    #1;
    if (g0 || !m0_req)
      gen(p_req0, p_rd0, m0_req, m0_rd_bwt, m0_addr, m0_wdata);
    if (g1 || !m1_req)
      gen(p_req1, p_rd1, m1_req, m1_rd_bwt, m1_addr, m1_wdata);
    req_wqfull = ($urandom_range(99) < p_rqf);
    wdq_wqfull = ($urandom_range(99) < p_wqf);
    if ($urandom_range(99) < p_push &&
        (allow_orphan || rdq.size() < tagq.size()))
      rdq.push_back(rnd128());
    drive_rdq();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int r0, input int r1,
                       input int d0, input int d1,
                       input int rf, input int wf,
                       input int pp);
    p_req0 = r0; p_req1 = r1; p_rd0 = d0; p_rd1 = d1;
    p_rqf = rf; p_wqf = wf; p_push = pp;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_rd_bwt = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_rd_bwt = 0; m1_addr = 0; m1_wdata = 0;
    req_wqfull = 0; wdq_wqfull = 0;
    drive_rdq();
  endtask

  // read-return monitor: pops expected returns on each rvalid
  always @(negedge mclk) begin
    if (m0_rvalid || m1_rvalid) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_rvalid: got m0=%0b m1=%0b want none",
                 m0_rvalid, m1_rvalid);
      end else begin
        ret_t r;
        r = expq.pop_front();
        chk("rv_m0", 128'(m0_rvalid), 128'(!r.who));
        chk("rv_m1", 128'(m1_rvalid), 128'(r.who));
        chk("rdata", r.who ? m1_rdata : m0_rdata, r.d);
        if (r.who) last_d1 = r.d;
        else       last_d0 = r.d;
      end
    end
    if (!m0_rvalid) chk("hold_m0", m0_rdata, last_d0);
    if (!m1_rvalid) chk("hold_m1", m1_rdata, last_d1);
  end

  task automatic model_reset();
    tagq.delete();
    rdq.delete();
    expq.delete();
    last = 1'b1;
    err_m = 1'b0;
    last_d0 = '0;
    last_d1 = '0;
    allow_orphan = 1'b0;
  endtask

  task automatic drain();
    knobs(0, 0, 0, 0, 0, 0, 100);
    for (int i = 0; i < 200; i++) begin
      if (tagq.size() == 0 && expq.size() == 0) break;
      step();
    end
    step();
    chk("drain_tags", 128'(tagq.size()), 128'(0));
    chk("drain_rets", 128'(expq.size()), 128'(0));
  endtask

  initial begin
    model_reset();
    knobs(0, 0, 0, 0, 0, 0, 0);
    clear_inputs();
    #1;
    chk("rst_m0_rvalid", 128'(m0_rvalid), 128'(0));
    chk("rst_m1_rvalid", 128'(m1_rvalid), 128'(0));
    chk("rst_m0_rdata", m0_rdata, 128'(0));
    chk("rst_m1_rdata", m1_rdata, 128'(0));
    chk("rst_arb_err", 128'(arb_err), 128'(0));
    chk("rst_req_wen", 128'(req_wen), 128'(0));
    chk("rst_rdq_rnext", 128'(rdq_rnext), 128'(0));
    @(negedge mclk);
    mrst_n = 1'b1;
    @(posedge mclk);
    #1;

    // single read from m0, data returned a few cycles later
    m0_req = 1; m0_rd_bwt = 1; m0_addr = 32'h0000_1000;
    step();
    step();
    step();
    rdq.push_back({4{32'hA5A5_A5A5}});
    drive_rdq();
    run(4);

    // both masters writing continuously
    knobs(100, 100, 0, 0, 0, 0, 0);
    m0_req = 1; m0_rd_bwt = 0; m0_wdata = rnd128();
    m1_req = 1; m1_rd_bwt = 0; m1_wdata = rnd128();
    run(20);

    // req queue full for 5 cycles
    knobs(100, 100, 0, 0, 100, 0, 0);
    req_wqfull = 1;
    run(5);
    knobs(100, 100, 0, 0, 0, 0, 0);
    run(5);

    // wdq full: m0 writes blocked, m1 reads proceed
    knobs(100, 100, 0, 100, 0, 100, 40);
    run(20);

    // tag fifo fills with m1 reads, then drains
    knobs(100, 100, 0, 100, 0, 0, 0);
    run(20);
    knobs(100, 100, 0, 100, 0, 0, 30);
    run(40);

    // broad random traffic
    knobs(60, 60, 50, 50, 15, 15, 50);
    run(2000);
    drain();

    // orphan rdq data with no outstanding tags
    allow_orphan = 1'b1;
    rdq.push_back(rnd128());
    allow_orphan = 1'b0;
    drive_rdq();
    run(4);

    // random traffic then reset mid-operation
    knobs(70, 70, 60, 60, 10, 10, 30);
    run(300);
    mrst_n = 1'b0;
    model_reset();
    clear_inputs();
    #1;
    chk("midrst_m0_rvalid", 128'(m0_rvalid), 128'(0));
    chk("midrst_m1_rvalid", 128'(m1_rvalid), 128'(0));
    chk("midrst_arb_err", 128'(arb_err), 128'(0));
    @(negedge mclk);
    mrst_n = 1'b1;
    @(posedge mclk);
    #1;
    knobs(60, 60, 50, 50, 15, 15, 50);
    run(500);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
